alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters, for example a decode-side issue port and a test/debug sequencer.
- Grants round-robin, latches the winning operands, drives the ALU for one cycle, captures the result, and returns it to the winner over a valid/ready response handshake.
- Sits between the requesters and the ALU instance; one operation is in flight at a time.

---
 rtl/cpu_types_pkg.sv | 32 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: ALU operation encoding, word type, ALU arbiter FSM states
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // ALU operation encoding; ALU_SLL must stay at 0 (reset value of latched op)
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_NOR  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_SLTU = 4'd10
    } aluop_t;

    // ALU arbiter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int unsigned ARB_REQS = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant from request valids and last-grant pointer
//
// Ports:
//   valid0_i    requester 0 has an operation
//   valid1_i    requester 1 has an operation
//   last_i      index of the requester granted most recently
//   gnt_valid_o some requester is granted
//   gnt_idx_o   index of the granted requester (meaningful when gnt_valid_o)
module rr_arb2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    always_comb begin
        gnt_valid_o = valid0_i | valid1_i;
        // Under contention the requester that did not win last time goes next;
        // otherwise the lone requester wins (idx 1 only if requester 1 asks).
        if (valid0_i && valid1_i) begin
            gnt_idx_o = ~last_i;
        end else begin
            gnt_idx_o = valid1_i;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of one combinational ALU between two requesters
//
// Optional build macro: ALU_ARB_STATS_EN adds saturating per-requester grant counters.
//
// Ports:
//   grant_cnt0/1          (ALU_ARB_STATS_EN only) accept-handshake counts, saturating
//   CLK, RST              clock, synchronous active-high reset
//   reqX_valid/ready      operation request handshake, X = 0/1
//   reqX_porta/portb/aluop operands and operation of requester X
//   rspX_valid/ready      result handshake towards requester X
//   rsp_result, rsp_zero  captured ALU result and zero flag (shared bus)
//   alu_porta/portb/aluop drive to the ALU, always from latched registers
//   alu_outport, alu_zero result from the ALU
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = 32
`ifdef ALU_ARB_STATS_EN
   ,parameter int unsigned CNT_W  = 16
`endif
) (
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
`endif
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_porta,
    input  logic [DATA_W-1:0] req0_portb,
    input  aluop_t            req0_aluop,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_porta,
    input  logic [DATA_W-1:0] req1_portb,
    input  aluop_t            req1_aluop,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic [DATA_W-1:0] alu_porta,
    output logic [DATA_W-1:0] alu_portb,
    output aluop_t            alu_aluop,
    input  logic [DATA_W-1:0] alu_outport,
    input  logic              alu_zero
);

    arb_state_t        state_q, state_d;
    logic [DATA_W-1:0] porta_q, porta_d;
    logic [DATA_W-1:0] portb_q, portb_d;
    aluop_t            op_q, op_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              tag_q, tag_d;
    logic              last_q, last_d;

    logic gnt_valid;
    logic gnt_idx;
    logic accept;
    logic rsp_done;

    rr_arb2 u_rr_arb2 (
        .valid0_i    (req0_valid),
        .valid1_i    (req1_valid),
        .last_i      (last_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // Grants are only offered in IDLE, so acceptance and response never overlap
    assign accept     = (state_q == IDLE) && gnt_valid;
    assign req0_ready = accept && !gnt_idx;
    assign req1_ready = accept &&  gnt_idx;

    assign rsp0_valid = (state_q == RESP) && !tag_q;
    assign rsp1_valid = (state_q == RESP) &&  tag_q;
    assign rsp_done   = tag_q ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;

    assign alu_porta  = porta_q;
    assign alu_portb  = portb_q;
    assign alu_aluop  = op_q;

    always_comb begin
        state_d  = state_q;
        porta_d  = porta_q;
        portb_d  = portb_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        tag_d    = tag_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    porta_d = gnt_idx ? req1_porta : req0_porta;
                    portb_d = gnt_idx ? req1_portb : req0_portb;
                    op_d    = gnt_idx ? req1_aluop : req0_aluop;
                    tag_d   = gnt_idx;
                    last_d  = gnt_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_outport;
                zero_d   = alu_zero;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            porta_q  <= '0;
            portb_q  <= '0;
            op_q     <= ALU_SLL;
            result_q <= '0;
            zero_q   <= 1'b0;
            tag_q    <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            porta_q  <= porta_d;
            portb_q  <= portb_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            tag_q    <= tag_d;
            last_q   <= last_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + 1'b1;
            end
            if (req1_ready && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + 1'b1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed table-driven bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned DATA_W = 32;
`ifdef ALU_ARB_STATS_EN
    localparam int unsigned CNT_W = 2;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic              req0_valid, req0_ready;
    logic [DATA_W-1:0] req0_porta, req0_portb;
    aluop_t            req0_aluop;
    logic              req1_valid, req1_ready;
    logic [DATA_W-1:0] req1_porta, req1_portb;
    aluop_t            req1_aluop;
    logic              rsp0_valid, rsp0_ready;
    logic              rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic [DATA_W-1:0] alu_porta, alu_portb, alu_outport;
    aluop_t            alu_aluop;
    logic              alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_arbiter #(
        .DATA_W (DATA_W)
`ifdef ALU_ARB_STATS_EN
       ,.CNT_W  (CNT_W)
`endif
    ) dut (
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1),
`endif
        .CLK         (CLK),
        .RST         (RST),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_porta  (req0_porta),
        .req0_portb  (req0_portb),
        .req0_aluop  (req0_aluop),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_porta  (req1_porta),
        .req1_portb  (req1_portb),
        .req1_aluop  (req1_aluop),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .alu_porta   (alu_porta),
        .alu_portb   (alu_portb),
        .alu_aluop   (alu_aluop),
        .alu_outport (alu_outport),
        .alu_zero    (alu_zero)
    );

    // Behavioural stand-in for the shared combinational ALU
    always_comb begin
        case (alu_aluop)
            ALU_SLL: alu_outport = alu_porta << alu_portb[4:0];
            ALU_SRL: alu_outport = alu_porta >> alu_portb[4:0];
            ALU_SRA: alu_outport = $unsigned($signed(alu_porta) >>> alu_portb[4:0]);
            ALU_ADD: alu_outport = alu_porta + alu_portb;
            ALU_SUB: alu_outport = alu_porta - alu_portb;
            ALU_AND: alu_outport = alu_porta & alu_portb;
            ALU_OR:  alu_outport = alu_porta | alu_portb;
            ALU_XOR: alu_outport = alu_porta ^ alu_portb;
            ALU_NOR: alu_outport = ~(alu_porta | alu_portb);
            default: alu_outport = '0;
        endcase
        alu_zero = (alu_outport == '0);
    end

    typedef struct {
        logic        id;
        aluop_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic id, input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_aluop = op; req1_porta = a; req1_portb = b;
        end else begin
            req0_valid = 1'b1; req0_aluop = op; req0_porta = a; req0_portb = b;
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, ALU_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
        vecs[1] = '{1'b1, ALU_SUB, 32'h1234_ABCD, 32'h1234_ABCD, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b0, ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0};
        vecs[3] = '{1'b1, ALU_OR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1'b0};
        vecs[4] = '{1'b0, ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        vecs[5] = '{1'b1, ALU_SLL, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 1'b0};
        vecs[6] = '{1'b0, ALU_SRL, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
        vecs[7] = '{1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};

        RST = 1'b1;
        req0_valid = 1'b0; req0_porta = '0; req0_portb = '0; req0_aluop = ALU_SLL;
        req1_valid = 1'b0; req1_porta = '0; req1_portb = '0; req1_aluop = ALU_SLL;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (3) tick();

        chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_zero", {31'b0, rsp_zero}, 32'd0);
        chk("rst_alu_porta", alu_porta, 32'd0);
        chk("rst_alu_aluop", {28'b0, alu_aluop}, 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk("rst_cnt0", {30'b0, grant_cnt0}, 32'd0);
        chk("rst_cnt1", {30'b0, grant_cnt1}, 32'd0);
`endif
        RST = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Single ops from the table, one requester at a time
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("v%0d_ready", i), {30'b0, req1_ready, req0_ready}, vecs[i].id ? 32'd2 : 32'd1);
            tick();
            req0_valid = 1'b0; req1_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_exec_rsp", i), {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
            tick();
            chk($sformatf("v%0d_rsp_valid", i), {30'b0, rsp1_valid, rsp0_valid}, vecs[i].id ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_result", i), rsp_result, vecs[i].res);
            chk($sformatf("v%0d_zero", i), {31'b0, rsp_zero}, {31'b0, vecs[i].z});
            tick();
        end

        // Contention: both held valid; last grant was requester 1, so 0,1,0,1
        drive(1'b0, ALU_AND, 32'hFF00_FF00, 32'h0F0F_0F0F);
        drive(1'b1, ALU_OR,  32'hFF00_FF00, 32'h0F0F_0F0F);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("cont%0d_grant", k), {30'b0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            tick();
            chk($sformatf("cont%0d_rsp_valid", k), {30'b0, rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("cont%0d_result", k), rsp_result, (k % 2 == 0) ? 32'h0F00_0F00 : 32'hFF0F_FF0F);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure on requester 0 while requester 1 waits
        rsp0_ready = 1'b0;
        drive(1'b0, ALU_ADD, 32'h0000_0010, 32'h0000_0020);
        drive(1'b1, ALU_SUB, 32'h0000_0009, 32'h0000_0004);
        #1;
        chk("bp_grant0", {30'b0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        req0_porta = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d_rsp0_valid", c), {31'b0, rsp0_valid}, 32'd1);
            chk($sformatf("bp%0d_result", c), rsp_result, 32'h0000_0030);
            chk($sformatf("bp%0d_req1_ready", c), {31'b0, req1_ready}, 32'd0);
            chk($sformatf("bp%0d_alu_porta", c), alu_porta, 32'h0000_0010);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        #1;
        chk("bp_idle_rsp0", {31'b0, rsp0_valid}, 32'd0);
        chk("bp_req1_ready", {30'b0, req1_ready, req0_ready}, 32'd2);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_rsp1_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd2);
        chk("bp_rsp1_result", rsp_result, 32'h0000_0005);
        tick();

        // Reset while requester 0's op is in EXEC
        drive(1'b0, ALU_ADD, 32'h0000_0100, 32'h0000_0001);
        #1;
        chk("mid_grant0", {30'b0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("mid_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
        chk("mid_valids", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("mid_result", rsp_result, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("mid%0d_no_rsp", c), {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
        end
        drive(1'b0, ALU_ADD, 32'h0000_0100, 32'h0000_0001);
        drive(1'b1, ALU_ADD, 32'h0000_0200, 32'h0000_0002);
        #1;
        chk("mid_after_grant0", {30'b0, req1_ready, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("mid_after_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd1);
        chk("mid_after_result", rsp_result, 32'h0000_0101);
        tick();
`ifdef ALU_ARB_STATS_EN
        chk("stats_cnt0_after_rst", {30'b0, grant_cnt0}, 32'd1);
        chk("stats_cnt1_after_rst", {30'b0, grant_cnt1}, 32'd0);
        for (int n = 0; n < 4; n++) begin
            drive(1'b0, ALU_ADD, 32'h1, 32'h1);
            tick();
            req0_valid = 1'b0;
            tick();
            tick();
        end
        chk("stats_cnt0_sat", {30'b0, grant_cnt0}, 32'd3);
        chk("stats_cnt1_zero", {30'b0, grant_cnt1}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
